hps_pio_out: RTL and testbench

Avalon-MM memory-mapped output PIO slave: HPS/Nios writes drive an `out_port` bus toward FPGA fabric (LEDs, control strobes).
It is the write-direction counterpart of the existing input PIO and lives in the same Qsys system on the same lightweight bridge.
Beyond a plain data register it provides atomic bit-set/bit-clear and a hardware-timed pulse generator. Software can emit exact N-cycle pulses without polling.

---
 rtl/hps_pio_out.sv | 117 +++++++++++
 tb/tb_hps_pio_out.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_pio_out.sv
// +---------------------------------------------------------------------------+
// | hps_pio_out                                                               |
// | Avalon-MM output PIO with atomic set/clear and a timed pulse generator.   |
// | Optional: define HPS_PIO_OUT_SETCLR_EN to enable OUTSET/OUTCLEAR (4/5).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module hps_pio_out #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [2:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] c_ADDR_DATA   = 3'd0;
    localparam logic [2:0] c_ADDR_MASK   = 3'd2;
    localparam logic [2:0] c_ADDR_LEN    = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS = 3'd6;
`ifdef HPS_PIO_OUT_SETCLR_EN
    localparam logic [2:0] c_ADDR_SET    = 3'd4;
    localparam logic [2:0] c_ADDR_CLR    = 3'd5;
`endif

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_out;
    logic [31:0]           r_readdata;

    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_mask_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_busy_nxt;
    logic [DATA_WIDTH-1:0] w_out_nxt;
    logic [31:0]           w_rd;
    logic                  w_unused;

    assign w_wr_en  = chipselect & write;
    assign w_wdata  = writedata[DATA_WIDTH-1:0];
    assign w_unused = ^writedata;

    always_comb begin
        w_data_nxt = r_data;
        w_mask_nxt = r_mask;
        if (w_wr_en) begin
            case (address)
                c_ADDR_DATA: w_data_nxt = w_wdata;
                c_ADDR_MASK: w_mask_nxt = w_wdata;
`ifdef HPS_PIO_OUT_SETCLR_EN
                c_ADDR_SET:  w_data_nxt = r_data | w_wdata;
                c_ADDR_CLR:  w_data_nxt = r_data & ~w_wdata;
`endif
                default: ;
            endcase
        end
    end

    // A PULSE_LEN write always wins over the decrement, so it reloads or aborts.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_en && address == c_ADDR_LEN) begin
            w_cnt_nxt = writedata[CNT_WIDTH-1:0];
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
    end

    assign w_busy_nxt = (w_cnt_nxt != '0);
    assign w_out_nxt  = w_data_nxt ^ (w_busy_nxt ? w_mask_nxt : '0);

    always_comb begin
        w_rd = '0;
        if (chipselect) begin
            case (address)
                c_ADDR_DATA:   w_rd[DATA_WIDTH-1:0] = r_data;
                c_ADDR_MASK:   w_rd[DATA_WIDTH-1:0] = r_mask;
                c_ADDR_LEN:    w_rd[CNT_WIDTH-1:0]  = r_cnt;
                c_ADDR_STATUS: w_rd[0]              = (r_cnt != '0);
                default: ;
            endcase
        end
    end

    // out_port is registered from next-state values so the pin never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_out      <= RESET_VALUE;
            r_readdata <= '0;
        end else begin
            r_data     <= w_data_nxt;
            r_mask     <= w_mask_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out      <= w_out_nxt;
            r_readdata <= w_rd;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule

`default_nettype wire

// File: tb/tb_hps_pio_out.sv
// +---------------------------------------------------------------------------+
// | tb_hps_pio_out                                                            |
// | Self-checking bench for hps_pio_out: directed scenarios plus random.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_hps_pio_out;

    localparam logic [7:0] c_RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: register contents as software sees them.
    logic [7:0]  m_data = c_RV;
    logic [7:0]  m_mask = 8'h00;
    int          m_cnt  = 0;
    logic [31:0] m_rd   = 32'd0;

    hps_pio_out #(
        .DATA_WIDTH (8),
        .RESET_VALUE(c_RV),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_out();
        return m_data ^ ((m_cnt != 0) ? m_mask : 8'h00);
    endfunction

    // Apply one bus cycle, advance the reference across the edge, settle 1ns.
    task automatic cycle(input logic rst, input logic cs, input logic [2:0] a,
                         input logic wr, input logic [31:0] wd);
        bit reload;
        reset = rst; chipselect = cs; address = a; write = wr; writedata = wd;
        @(posedge clk);
        m_rd = 32'd0;
        if (cs) begin
            case (a)
                3'd0: m_rd = {24'd0, m_data};
                3'd2: m_rd = {24'd0, m_mask};
                3'd3: m_rd = 32'(m_cnt);
                3'd6: m_rd = {31'd0, m_cnt != 0};
                default: m_rd = 32'd0;
            endcase
        end
        reload = cs && wr && a == 3'd3;
        if (rst) begin
            m_data = c_RV; m_mask = 8'h00; m_cnt = 0; m_rd = 32'd0;
        end else begin
            if (cs && wr) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd2: m_mask = wd[7:0];
                    3'd3: m_cnt  = int'(wd & 32'h0000_FFFF);
`ifdef HPS_PIO_OUT_SETCLR_EN
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
`endif
                    default: ;
                endcase
            end
            if (!reload && m_cnt > 0) m_cnt = m_cnt - 1;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 3'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 3'd0, 1'b0, 32'd0);
        vectors++;
        if (out_port !== 8'hA5) begin
            miscompares++; $display("FAIL reset_out out_port=%h expected=%h", out_port, 8'hA5);
        end
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL reset_rd readdata=%h expected=%h", readdata, 32'd0);
        end
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'h0000_00A5) begin
            miscompares++; $display("FAIL reset_read_data readdata=%h expected=%h", readdata, 32'hA5);
        end
    endtask

    task automatic test_data();
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'hFFFF_FF3C);
        vectors++;
        if (out_port !== 8'h3C) begin
            miscompares++; $display("FAIL data_write out_port=%h expected=%h", out_port, 8'h3C);
        end
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'h0000_003C) begin
            miscompares++; $display("FAIL data_read readdata=%h expected=%h", readdata, 32'h3C);
        end
        cycle(1'b0, 1'b1, 3'd1, 1'b1, 32'h0000_00FF);
        cycle(1'b0, 1'b1, 3'd1, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0 || out_port !== 8'h3C) begin
            miscompares++;
            $display("FAIL reserved readdata=%h out_port=%h expected=0/3c", readdata, out_port);
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL cs_low_read readdata=%h expected=0", readdata);
        end
    endtask

    task automatic test_setclr();
        logic [7:0] exp_set, exp_clr;
`ifdef HPS_PIO_OUT_SETCLR_EN
        exp_set = 8'hCF; exp_clr = 8'hCC;
`else
        exp_set = 8'h0F; exp_clr = 8'h0F;
`endif
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0000_000F);
        cycle(1'b0, 1'b1, 3'd4, 1'b1, 32'h0000_00C0);
        vectors++;
        if (out_port !== exp_set) begin
            miscompares++; $display("FAIL outset out_port=%h expected=%h", out_port, exp_set);
        end
        cycle(1'b0, 1'b1, 3'd5, 1'b1, 32'h0000_0003);
        vectors++;
        if (out_port !== exp_clr) begin
            miscompares++; $display("FAIL outclear out_port=%h expected=%h", out_port, exp_clr);
        end
        cycle(1'b0, 1'b1, 3'd4, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL outset_read readdata=%h expected=0", readdata);
        end
    endtask

    task automatic test_pulse();
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 3'd2, 1'b1, 32'h1);
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd5);
        for (int i = 0; i < 5; i++) begin
            logic [2:0]  a;
            logic [31:0] exp;
            vectors++;
            if (out_port !== 8'h01) begin
                miscompares++; $display("FAIL pulse_high[%0d] out_port=%h expected=01", i, out_port);
            end
            a   = (i % 2 == 0) ? 3'd6 : 3'd3;
            exp = (a == 3'd6) ? 32'd1 : 32'(5 - i);
            cycle(1'b0, 1'b1, a, 1'b0, 32'd0);
            vectors++;
            if (readdata !== exp) begin
                miscompares++;
                $display("FAIL pulse_read[%0d] addr=%0d readdata=%h expected=%h", i, a, readdata, exp);
            end
        end
        vectors++;
        if (out_port !== 8'h00) begin
            miscompares++; $display("FAIL pulse_end out_port=%h expected=00", out_port);
        end
        cycle(1'b0, 1'b1, 3'd6, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL pulse_status_idle readdata=%h expected=0", readdata);
        end
    endtask

    task automatic test_reload();
        int busy_cycles;
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd10);
        idle(); idle();
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd2);
        busy_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_port === 8'h01) busy_cycles++;
            idle();
        end
        vectors++;
        if (busy_cycles != 2) begin
            miscompares++; $display("FAIL reload busy_cycles=%0d expected=2", busy_cycles);
        end
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd10);
        idle(); idle();
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd0);
        vectors++;
        if (out_port !== 8'h00) begin
            miscompares++; $display("FAIL abort out_port=%h expected=00", out_port);
        end
        cycle(1'b0, 1'b1, 3'd6, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL abort_status readdata=%h expected=0", readdata);
        end
    endtask

    task automatic test_reset_midpulse();
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 32'd8);
        idle(); idle(); idle();
        cycle(1'b1, 1'b1, 3'd0, 1'b1, 32'h0000_0055);
        vectors++;
        if (out_port !== c_RV || readdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid out_port=%h readdata=%h expected=%h/0", out_port, readdata, c_RV);
        end
        cycle(1'b0, 1'b1, 3'd6, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL reset_mid_status readdata=%h expected=0", readdata);
        end
        cycle(1'b0, 1'b1, 3'd3, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'd0) begin
            miscompares++; $display("FAIL reset_mid_cnt readdata=%h expected=0", readdata);
        end
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 32'd0);
        vectors++;
        if (readdata !== 32'h0000_00A5 || out_port !== c_RV) begin
            miscompares++;
            $display("FAIL reset_mid_discard readdata=%h out_port=%h expected=a5/a5", readdata, out_port);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic        rst, cs, wr;
            logic [2:0]  a;
            logic [31:0] wd;
            rst = ($urandom_range(0, 60) == 0);
            cs  = ($urandom_range(0, 4) != 0);
            wr  = ($urandom_range(0, 1) == 1);
            a   = 3'($urandom_range(0, 7));
            wd  = $urandom;
            if (a == 3'd3 && $urandom_range(0, 3) != 0) wd = 32'($urandom_range(0, 12));
            cycle(rst, cs, a, wr, wd);
            vectors++;
            if (out_port !== m_out() || readdata !== m_rd) begin
                miscompares++;
                $display("FAIL random[%0d] out_port=%h readdata=%h expected=%h/%h",
                         i, out_port, readdata, m_out(), m_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data();
        test_setclr();
        test_pulse();
        test_reload();
        test_reset_midpulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
